hyperbus_wb: RTL

- Wishbone B3 classic 32-bit slave bridge.
- Converts bus cycles into single-word requests on the user-side request/response interface of the Hyperbus dual-port FIFO block.
- Sits directly upstream of that FIFO, in the user clock domain.
- Adds byte-lane write support via read-modify-write, a response timeout, and cycle-abort handling.

---
 rtl/hyperbus_wb.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_wb.sv
// ============================================================================
//  Module   : hyperbus_wb
//  Purpose  : Wishbone B3 classic 32-bit slave bridge onto the user-side
//             single-word request/response interface of the Hyperbus
//             dual-port FIFO. Partial-lane writes become read-modify-write
//             sequences. Waits for FIFO responses are bounded by a timeout,
//             and Wishbone cycle aborts are handled without cancelling FIFO
//             traffic that is already in flight.
//  Ports    : clk, rst_n                   - user clock, async active-low reset
//             wb_cyc_i .. wb_sel_i         - Wishbone slave inputs
//             wb_dat_o, wb_ack_o, wb_err_o - Wishbone slave outputs
//             rrq, wrq, adr_o, tx_dat_o    - request side towards the FIFO
//             tx_ready, rx_dat_i, rx_valid - response side from the FIFO
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyperbus_wb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_SHIFT = 1,
   parameter int TIMEOUT    = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_we_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic                    rrq,
   output logic                    wrq,
   output logic [ADDR_WIDTH-1:0]   adr_o,
   output logic [DATA_WIDTH-1:0]   tx_dat_o,
   input  logic                    tx_ready,
   input  logic [DATA_WIDTH-1:0]   rx_dat_i,
   input  logic                    rx_valid
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit TMO_EN = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [LANES-1:0] SEL_ALL = '1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      MERGE   = 3'd3,
      WR_REQ  = 3'd4,
      WR_WAIT = 3'd5,
      RESP    = 3'd6
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic                   resp_err;     // the transition into RESP is a timeout
   logic                   tmo_hit;
   logic [CNT_W-1:0]       tmo_cnt;
   logic                   is_rmw;       // write with a partial lane mask
   logic [LANES-1:0]       sel_q;
   logic [DATA_WIDTH-1:0]  wdat_q;
   logic [DATA_WIDTH-1:0]  rdat_q;       // read phase data of an RMW
   logic [DATA_WIDTH-1:0]  merged;

   assign tmo_hit = TMO_EN && (tmo_cnt == CNT_LAST);

   // Selected lanes come from the Wishbone write data, the rest from memory.
   always_comb begin
      merged = '0;
      for (int i = 0; i < LANES; i++) begin
         merged[8*i +: 8] = sel_q[i] ? wdat_q[8*i +: 8] : rdat_q[8*i +: 8];
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rrq       = 1'b0;
      wrq       = 1'b0;
      resp_err  = 1'b0;
      case (state)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               if (wb_we_i && (wb_sel_i == '0))        state_nxt = RESP;
               else if (wb_we_i && (wb_sel_i == SEL_ALL)) state_nxt = WR_REQ;
               else                                     state_nxt = RD_REQ;
            end
         end
         RD_REQ: begin
            rrq       = 1'b1;
            state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            if (rx_valid) begin
               state_nxt = is_rmw ? MERGE : RESP;
            end else if (tmo_hit) begin
               // An RMW timing out here never reaches its write phase.
               state_nxt = RESP;
               resp_err  = 1'b1;
            end
         end
         MERGE:   state_nxt = WR_REQ;
         WR_REQ: begin
            wrq       = 1'b1;
            state_nxt = WR_WAIT;
         end
         WR_WAIT: begin
            if (tx_ready) begin
               state_nxt = RESP;
            end else if (tmo_hit) begin
               state_nxt = RESP;
               resp_err  = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         adr_o    <= '0;
         tx_dat_o <= '0;
         tmo_cnt  <= '0;
         is_rmw   <= 1'b0;
         sel_q    <= '0;
         wdat_q   <= '0;
         rdat_q   <= '0;
      end else begin
         // Ack/err are registered so they are high exactly during RESP, and
         // only if the master still holds the cycle open.
         wb_ack_o <= (state_nxt == RESP) && wb_cyc_i && !resp_err;
         wb_err_o <= (state_nxt == RESP) && wb_cyc_i &&  resp_err;

         // Counter restarts on every state entry and runs only while waiting.
         if (state_nxt != state)
            tmo_cnt <= '0;
         else if ((state == RD_WAIT) || (state == WR_WAIT))
            tmo_cnt <= tmo_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  adr_o  <= wb_adr_i >> ADDR_SHIFT;
                  is_rmw <= wb_we_i && (wb_sel_i != SEL_ALL);
                  sel_q  <= wb_sel_i;
                  wdat_q <= wb_dat_i;
                  if (wb_we_i && (wb_sel_i == SEL_ALL))
                     tx_dat_o <= wb_dat_i;
               end
            end
            RD_WAIT: begin
               if (rx_valid) begin
                  if (is_rmw) rdat_q   <= rx_dat_i;
                  else        wb_dat_o <= rx_dat_i;
               end
            end
            MERGE:   tx_dat_o <= merged;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
